// File: rtl/run_ctrl.sv
// run_ctrl: run/step/halt sequencer for a multicycle core.
// It holds the core in reset for RST_CYCLES, then runs it until halted or
// until MAX_CYCLES enabled cycles have elapsed, and optionally single-steps it.
//
// Ports:
//   i_clk          system clock, all state updates on its rising edge
//   i_rst_n        asynchronous active-low reset
//   i_start        level; leaves HOLD once the reset window is over, and leaves DONE
//   i_halt_req     level; stops the current run (the requesting cycle still counts)
//   i_step_mode    level; selects single-step operation
//   i_step         level; each 0->1 transition grants one core cycle in STEP
//   o_core_reset   active-high reset to the core (high in HOLD)
//   o_core_en      clock enable to the core
//   o_running      high in RUN or STEP
//   o_done         high in DONE
//   o_cycle_count  core-enabled cycles in the current run, saturating
//   o_state        HOLD=0, RUN=1, STEP=2, DONE=3
//
// Optional feature: define RUN_CTRL_STEP_EN to build the STEP state and the
// step_mode/step handling. Without it those inputs are ignored and STEP is unreachable.
module run_ctrl #(
    parameter int RST_CYCLES = 2,
    parameter int MAX_CYCLES = 12,
    parameter int CYC_W      = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_halt_req,
    input  logic             i_step_mode,
    input  logic             i_step,
    output logic             o_core_reset,
    output logic             o_core_en,
    output logic             o_running,
    output logic             o_done,
    output logic [CYC_W-1:0] o_cycle_count,
    output logic [1:0]       o_state
);
    typedef enum logic [1:0] {HOLD = 2'd0, RUN = 2'd1, STEP = 2'd2, DONE = 2'd3} state_t;
    localparam logic [7:0] HOLD_LAST = 8'(RST_CYCLES - 1);
    state_t           r_state, w_next;
    logic [7:0]       r_hold_cnt;
    logic [CYC_W-1:0] r_cycle_count, w_cnt_inc;
    logic             w_hold_last, w_limit, w_step_grant, w_step_mode, w_restart;
`ifdef RUN_CTRL_STEP_EN
    logic r_step_d, r_step_edge;
    // The detected edge is registered so the granted cycle comes from a flop, not from the pin.
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_step_d    <= 1'b0;
            r_step_edge <= 1'b0;
        end else begin
            r_step_d    <= i_step;
            r_step_edge <= i_step & ~r_step_d;
        end
    assign w_step_grant = r_step_edge;
    assign w_step_mode  = i_step_mode;
`else
    logic w_unused_step;
    assign w_unused_step = i_step_mode ^ i_step;
    assign w_step_grant  = 1'b0;
    assign w_step_mode   = 1'b0;
`endif
    assign w_hold_last = r_hold_cnt == HOLD_LAST;
    assign w_restart   = (r_state == DONE) && i_start;
    assign w_cnt_inc   = &r_cycle_count ? r_cycle_count : r_cycle_count + CYC_W'(1);
    // The limit is judged on the value this enabled cycle produces.
    assign w_limit     = (MAX_CYCLES != 0) && o_core_en && (w_cnt_inc == CYC_W'(MAX_CYCLES));
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_state <= HOLD;
        else          r_state <= w_next;
    always_comb begin
        w_next = r_state;
        case (r_state)
            HOLD:      w_next = (w_hold_last && i_start) ? RUN : HOLD;
            RUN, STEP: w_next = (i_halt_req || w_limit) ? DONE : (w_step_mode ? STEP : RUN);
            DONE:      w_next = i_start ? HOLD : DONE;
        endcase
    end
    always_comb begin
        o_core_reset  = r_state == HOLD;
        o_core_en     = (r_state == RUN) || ((r_state == STEP) && w_step_grant);
        o_running     = (r_state == RUN) || (r_state == STEP);
        o_done        = r_state == DONE;
        o_state       = r_state;
        o_cycle_count = r_cycle_count;
    end
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n)                            r_hold_cnt <= 8'd0;
        else if (w_restart)                      r_hold_cnt <= 8'd0;
        else if (r_state == HOLD && !w_hold_last) r_hold_cnt <= r_hold_cnt + 8'd1;
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n)       r_cycle_count <= '0;
        else if (w_restart) r_cycle_count <= '0;
        else if (o_core_en) r_cycle_count <= w_cnt_inc;
endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
- REQ-001: Parameter RST_CYCLES, default 2, SHALL set the number of cycles core_reset stays asserted after entering HOLD (legal range 1..255).
- REQ-002: Parameter MAX_CYCLES, default 12, SHALL set the number of core-enabled cycles before automatic stop; 0 SHALL mean unlimited.
- REQ-003: Parameter CYC_W, default 32, SHALL set the width of cycle_count.
- REQ-004: clock  input  1  single system clock; all state SHALL update on its rising edge.
- REQ-005: reset  input  1  SHALL be asynchronous and active-low: low forces reset state immediately, release is sampled on clock.
- REQ-006: start  input  1  level; begins or restarts a run.
- REQ-007: halt_req  input  1  level; requests stop of the current run.
- REQ-008: step_mode  input  1  level; selects single-step operation.
- REQ-009: step  input  1  level; each 0->1 transition grants one core cycle in STEP.
- REQ-010: core_reset  output  1  active-high reset to the multicycle core.
- REQ-011: core_en  output  1  clock enable to the core.
- REQ-012: running  output  1  high in RUN or STEP.
- REQ-013: done  output  1  high in DONE.
- REQ-014: cycle_count  output  CYC_W  number of core-enabled cycles in the current run.
- REQ-015: state  output  2  encoding HOLD=0, RUN=1, STEP=2, DONE=3.

Function
- REQ-016: Outputs SHALL be Moore-decoded from registered state, except core_en in STEP, which SHALL use the registered step edge.
- REQ-017: HOLD: core_reset=1, core_en=0; hold counter SHALL increment each cycle and saturate at RST_CYCLES-1.
- REQ-018: HOLD->RUN SHALL occur at the edge where the hold counter equals RST_CYCLES-1 and start=1; otherwise HOLD SHALL persist with core_reset=1.
- REQ-019: RUN: core_reset=0, core_en=1 every cycle; cycle_count SHALL increment on every edge where core_en=1.
- REQ-020: cycle_count SHALL saturate at all-ones, never wrapping.
- REQ-021: RUN->DONE SHALL occur when halt_req=1, or when MAX_CYCLES!=0 and the increment brings cycle_count to MAX_CYCLES; the cycle with halt_req high SHALL still be enabled and counted.
- REQ-022: RUN->STEP when step_mode=1 and halt_req=0; STEP->RUN when step_mode=0 and halt_req=0.
- REQ-023: STEP: core_en SHALL be high for exactly one cycle per detected step rising edge; a held-high step SHALL grant no further cycles.
- REQ-024: STEP->DONE SHALL occur on halt_req=1, or on MAX_CYCLES being reached via granted steps.
- REQ-025: Priority SHALL be halt_req > MAX_CYCLES limit > step_mode.
- REQ-026: DONE: core_en=0, core_reset=0, done=1, cycle_count held; start=1 SHALL move to HOLD, clearing cycle_count and the hold counter.
- REQ-027: start SHALL be ignored in RUN and STEP.

Reset
- REQ-028: reset low SHALL force state=HOLD, hold counter=0, step-edge register=0, cycle_count=0, core_reset=1, core_en=0, running=0, done=0.
- REQ-029: reset asserted mid-run SHALL drop core_en immediately (asynchronously) and discard the run.

Configuration
- REQ-030: Macro RUN_CTRL_STEP_EN defined SHALL compile in STEP state, step_mode and step handling.
- REQ-031: Without RUN_CTRL_STEP_EN, step_mode and step SHALL be ignored, state 2 SHALL be unreachable, and ports SHALL remain present.

Verification
- REQ-032: reset low 2 cycles, release with start=1 -> core_reset high 2 cycles, then RUN; core_en high exactly 12 cycles; DONE with cycle_count=12.
- REQ-033: halt_req pulsed for one cycle at the 5th RUN cycle -> DONE next cycle, cycle_count=5, core_en low afterwards.
- REQ-034: step_mode=1 after 3 RUN cycles, then 4 step pulses, step held high 5 cycles on the last pulse -> cycle_count=7, one core_en per pulse.
- REQ-035: MAX_CYCLES=0 with CYC_W=4 run 20 cycles -> cycle_count saturates at 15, no DONE.
- REQ-036: reset low mid-RUN at count 6 -> core_en low immediately; HOLD with cycle_count=0; restart then yields 12 cycles.
- REQ-037: DONE, then start=1 -> HOLD, count cleared, full 12-cycle run repeats; halt_req and limit coincident -> single DONE entry.
